aes_ctr_stream: RTL and testbench

- CTR-mode front end for the AES-256 encrypt core. It accepts a 32-bit plaintext/ciphertext word stream, generates counter blocks, and issues them to the core's ready/data_in/key interface.
- It XORs the core's data_out keystream with the packed input block and emits a 32-bit output stream.
- It sits directly upstream of the encrypt core and also consumes its result, so the core needs no system-level sequencing.

---
 rtl/aes_ctr_stream.sv | 164 ++++++++++++++++
 tb/tb_aes_ctr_stream.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - CTR-mode word-stream front end for the AES-256 encrypt core
`timescale 1ns/1ps
module aes_ctr_stream #(
    parameter int CTR_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [127:0] iv,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         core_ready,
    output logic [127:0] core_data_in,
    output logic [255:0] core_key,
    input  logic [127:0] core_data_out,
    input  logic         core_valid,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, FILL, XOR, DRAIN} state_t;

    state_t       state;
    logic [127:0] pt_buf, out_buf, ks_reg, counter;
    logic [1:0]   wcnt, last_idx, didx;
    logic         last_flag, ks_valid, req_pending, stop;

    // Only the low CTR_W bits count; the rest of the block is fixed nonce.
    function automatic logic [127:0] ctr_inc(input logic [127:0] c);
        logic [127:0] r;
        r = c;
        r[CTR_W-1:0] = c[CTR_W-1:0] + CTR_W'(1);
        return r;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] b, input logic [1:0] i);
        logic [31:0] w;
        case (i)
            2'd0:    w = b[127:96];
            2'd1:    w = b[95:64];
            2'd2:    w = b[63:32];
            default: w = b[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] b, input logic [1:0] i,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = b;
        case (i)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);
    assign out_data  = word_of(out_buf, didx);
    assign out_last  = (state == DRAIN) && last_flag && (didx == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pt_buf       <= '0;
            out_buf      <= '0;
            ks_reg       <= '0;
            counter      <= '0;
            wcnt         <= '0;
            last_idx     <= '0;
            didx         <= '0;
            last_flag    <= 1'b0;
            ks_valid     <= 1'b0;
            req_pending  <= 1'b0;
            stop         <= 1'b0;
            busy         <= 1'b0;
            core_ready   <= 1'b0;
            core_data_in <= '0;
            core_key     <= '0;
        end else begin
            // Keystream engine: one request in flight, prefetching while data drains/fills.
            if (core_ready) begin
                core_ready <= 1'b0;
            end else if (busy && !ks_valid && !req_pending && !stop) begin
                core_ready   <= 1'b1;
                core_data_in <= counter;
                req_pending  <= 1'b1;
            end
            if (core_valid && req_pending) begin
                req_pending <= 1'b0;
                counter     <= ctr_inc(counter);
                if (!stop) begin
                    ks_reg   <= core_data_out;
                    ks_valid <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (busy) begin
                        if (!req_pending) busy <= 1'b0;
                    end else if (start && !req_pending) begin
                        core_key     <= key;
                        counter      <= iv;
                        busy         <= 1'b1;
                        stop         <= 1'b0;
                        pt_buf       <= '0;
                        wcnt         <= '0;
                        core_ready   <= 1'b1;
                        core_data_in <= iv;
                        req_pending  <= 1'b1;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        pt_buf <= put_word(pt_buf, wcnt, in_data);
                        if (wcnt == 2'd3 || in_last) begin
                            last_idx  <= wcnt;
                            last_flag <= in_last;
                            state     <= XOR;
                        end else begin
                            wcnt <= wcnt + 2'd1;
                        end
                    end
                end
                XOR: begin
                    if (ks_valid) begin
                        out_buf  <= pt_buf ^ ks_reg;
                        ks_valid <= 1'b0;
                        didx     <= '0;
                        if (last_flag) stop <= 1'b1;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (didx == last_idx) begin
                            if (last_flag) begin
                                state <= IDLE;
                                if (!req_pending) busy <= 1'b0;
                            end else begin
                                pt_buf <= '0;
                                wcnt   <= '0;
                                state  <= FILL;
                            end
                        end else begin
                            didx <= didx + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - randomized bench for aes_ctr_stream with a behavioural core and CTR model
`timescale 1ns/1ps
module tb_aes_ctr_stream;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_IV  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n, start, in_valid, in_last, in_ready, out_valid, out_last, out_ready;
    logic [255:0] key, core_key;
    logic [127:0] iv, core_data_in, core_data_out;
    logic [31:0]  in_data, out_data;
    logic         core_ready, core_valid, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] req_q[$];
    logic [255:0] reqk_q[$];
    logic [127:0] req_log[$];
    int           core_lat_min = 1;
    int           core_lat_max = 5;
    bit           core_idle = 1'b1;

    logic [31:0]  msg_w[64];
    logic [31:0]  exp_w[64];

    always #5 clk = ~clk;

    aes_ctr_stream #(.CTR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .iv(iv),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .core_ready(core_ready), .core_data_in(core_data_in), .core_key(core_key),
        .core_data_out(core_data_out), .core_valid(core_valid), .busy(busy)
    );

    // Stand-in for the AES core: real FIPS-197 answer for the known vector, a keyed mix otherwise.
    function automatic logic [127:0] fake_aes(input logic [255:0] k, input logic [127:0] d);
        logic [127:0] x;
        if (k == FIPS_KEY && d == FIPS_IV) return FIPS_CT;
        x = d ^ k[127:0] ^ k[255:128];
        x = {x[86:0], x[127:87]} ^ {4{32'h9e3779b9}};
        return x + {d[63:0], d[127:64]};
    endfunction

    function automatic logic [127:0] ctr_of(input logic [127:0] v, input int b);
        logic [127:0] r;
        r = v;
        r[31:0] = v[31:0] + 32'(b);
        return r;
    endfunction

    initial begin : core_monitor
        forever begin
            @(posedge clk); #1;
            if (core_ready === 1'b1) begin
                req_q.push_back(core_data_in);
                reqk_q.push_back(core_key);
                req_log.push_back(core_data_in);
            end
        end
    end

    initial begin : core_responder
        logic [127:0] d;
        logic [255:0] k;
        int lat;
        core_valid = 1'b0;
        core_data_out = '0;
        forever begin
            @(posedge clk); #2;
            if (req_q.size() > 0) begin
                d = req_q.pop_front();
                k = reqk_q.pop_front();
                core_idle = 1'b0;
                lat = $urandom_range(core_lat_max, core_lat_min);
                repeat (lat) @(posedge clk);
                #2;
                core_valid = 1'b1;
                core_data_out = fake_aes(k, d);
                @(posedge clk); #2;
                core_valid = 1'b0;
                core_idle = 1'b1;
            end
        end
    end

    task automatic wait_quiet();
        int c = 0;
        while (!(busy === 1'b0 && core_idle && req_q.size() == 0) && c < 500) begin
            @(posedge clk); #1; c++;
        end
        vectors++;
        if (c >= 500) begin
            miscompares++;
            $display("FAIL quiet_timeout: busy=%b core_idle=%b", busy, core_idle);
        end
    endtask

    task automatic pulse_start(input logic [255:0] k, input logic [127:0] v);
        key = k; iv = v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic produce(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = msg_w[i]; in_last = (i == n - 1);
            c = 0;
            while (in_ready !== 1'b1 && c < 3000) begin
                @(posedge clk); #1; c++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic consume(input int n, input int stall_word);
        int got = 0, cyc = 0, stall = 0;
        bit hold = 1'b0;
        logic [31:0] pd;
        logic pl;
        while (got < n && cyc < 3000) begin
            if (got == stall_word && out_valid === 1'b1 && stall < 5) begin
                out_ready = 1'b0; stall++;
            end else begin
                out_ready = ($urandom_range(3, 0) != 0);
            end
            if (hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    miscompares++;
                    $display("FAIL hold_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             out_valid, out_data, out_last, pd, pl);
                end
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_ready_drain: got %b expected 0", in_ready);
                end
                if (out_ready) begin
                    vectors++;
                    if (out_data !== exp_w[got] || out_last !== (got == n - 1)) begin
                        miscompares++;
                        $display("FAIL out_word%0d: got %h last=%b expected %h last=%b",
                                 got, out_data, out_last, exp_w[got], (got == n - 1));
                    end
                    got++;
                end
            end
            hold = (out_valid === 1'b1) && !out_ready;
            pd = out_data; pl = out_last;
            @(posedge clk); #1; cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (got != n) begin
            miscompares++;
            $display("FAIL out_count: got %0d expected %0d", got, n);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL extra_word: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic run_msg(input logic [255:0] k, input logic [127:0] v, input int n,
                           input bit zero_data, input int stall_word);
        int nb, c;
        logic [127:0] ks;
        nb = (n + 3) / 4;
        for (int i = 0; i < n; i++) begin
            msg_w[i] = zero_data ? 32'h0 : $urandom;
            ks = fake_aes(k, ctr_of(v, i / 4));
            exp_w[i] = msg_w[i] ^ 32'(ks >> (96 - 32 * (i % 4)));
        end
        wait_quiet();
        req_log.delete();
        pulse_start(k, v);
        vectors++;
        if (core_key !== k) begin
            miscompares++;
            $display("FAIL core_key: got %h expected %h", core_key, k);
        end
        fork
            produce(n);
            consume(n, stall_word);
        join
        c = 0;
        while (busy !== 1'b0 && c < 200) begin
            @(posedge clk); #1; c++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall: got %b expected 0", busy);
        end
        wait_quiet();
        vectors++;
        if (req_log.size() < nb || req_log.size() > nb + 1) begin
            miscompares++;
            $display("FAIL req_count: got %0d expected %0d or %0d", req_log.size(), nb, nb + 1);
        end
        for (int j = 0; j < req_log.size(); j++) begin
            vectors++;
            if (req_log[j] !== ctr_of(v, j)) begin
                miscompares++;
                $display("FAIL req%0d: got %h expected %h", j, req_log[j], ctr_of(v, j));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({in_ready, out_valid, out_last, core_ready, busy} !== 5'b0 || out_data !== 32'h0 ||
            core_data_in !== 128'h0 || core_key !== 256'h0) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b ov=%b ol=%b cr=%b busy=%b od=%h cdi=%h expected all zero",
                     tag, in_ready, out_valid, out_last, core_ready, busy, out_data, core_data_in);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset_state");
    endtask

    task automatic test_fips();
        run_msg(FIPS_KEY, FIPS_IV, 4, 1'b1, -1);
    endtask

    task automatic test_two_block();
        run_msg(FIPS_KEY, FIPS_IV, 8, 1'b0, -1);
        vectors++;
        if (req_log.size() < 2) begin
            miscompares++;
            $display("FAIL two_block_req: got %0d requests expected >= 2", req_log.size());
        end else if (req_log[1] !== 128'h00112233445566778899aabbccddef00) begin
            miscompares++;
            $display("FAIL two_block_req: got %h expected 00112233445566778899aabbccddef00", req_log[1]);
        end
    endtask

    task automatic test_wrap();
        logic [127:0] v;
        v = {{12{8'ha5}}, 32'hffffffff};
        run_msg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                v, 8, 1'b0, -1);
        vectors++;
        if (req_log.size() < 2) begin
            miscompares++;
            $display("FAIL wrap_req: got %0d requests expected >= 2", req_log.size());
        end else if (req_log[1] !== {{12{8'ha5}}, 32'h00000000}) begin
            miscompares++;
            $display("FAIL wrap_req: got %h expected a5..a5_00000000", req_log[1]);
        end
    endtask

    task automatic test_partial();
        int n;
        run_msg(FIPS_KEY, FIPS_IV, 2, 1'b0, -1);
        n = req_log.size();
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (req_log.size() != n || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_idle: got reqs=%0d busy=%b expected reqs=%0d busy=0",
                     req_log.size(), busy, n);
        end
    endtask

    task automatic test_backpressure();
        run_msg({8{$urandom}}, {4{$urandom}}, 8, 1'b0, 5);
    endtask

    task automatic test_reset_mid();
        int c, n;
        core_lat_min = 8; core_lat_max = 10;
        wait_quiet();
        req_log.delete();
        pulse_start(FIPS_KEY, FIPS_IV);
        c = 0;
        while (req_log.size() == 0 && c < 50) begin
            @(posedge clk); #1; c++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = req_log.size();
        wait_quiet();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || req_log.size() != n) begin
            miscompares++;
            $display("FAIL late_core_valid: got busy=%b ov=%b reqs=%0d expected 0 0 %0d",
                     busy, out_valid, req_log.size(), n);
        end
        core_lat_min = 1; core_lat_max = 5;
        run_msg(FIPS_KEY, FIPS_IV, 4, 1'b1, -1);
    endtask

    task automatic test_random();
        for (int m = 0; m < 4; m++) begin
            run_msg({8{$urandom}}, {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(12, 1), 1'b0, -1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key = '0; iv = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_fips();
        test_two_block();
        test_wrap();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
